// File: rtl/sync_fifo_srl_stream.sv
// Shallow SRL FIFO, valid/ready stream, FWFT output register, optional store-and-forward.
// Latency: bypass shows a word after its accepting edge; SRL words one edge after the output register frees.
// Backpressure: s_ready = SRL not full (registered decode, no path from m_ready); output holds while !m_ready.
module sync_fifo_srl_stream #(
   parameter int DWIDTH     = 16,
   parameter int AWIDTH     = 4,
   parameter bit PKT_MODE   = 1'b0,
   parameter int AFULL_LVL  = (1 << AWIDTH) - 2,
   parameter int AEMPTY_LVL = 1
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic [DWIDTH-1:0] s_data,
   input  logic              s_last,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DWIDTH-1:0] m_data,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [AWIDTH:0]   dcount,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              oversize
);

   localparam int              DEPTH   = 1 << AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0] ONE_C   = (AWIDTH+1)'(1);
   localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AFULL_LVL);
   localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AEMPTY_LVL);

   typedef enum logic {ST_STORE, ST_CUT} state_t;

   state_t            state_q, state_d;
   logic [DWIDTH:0]   srl_mem [DEPTH];
   logic [AWIDTH:0]   srl_cnt;
   logic [AWIDTH:0]   pkt_cnt;
   logic [AWIDTH-1:0] rd_idx;
   logic [DWIDTH:0]   head_word;
   logic              head_last;
   logic              wr_acc, out_free, load_ok, srl_load, bypass, srl_wr;
   logic              pkt_inc, pkt_dec;

   assign s_ready   = (srl_cnt != DEPTH_C);
   assign wr_acc    = s_valid & s_ready;
   assign out_free  = !m_valid | m_ready;
   assign load_ok   = !PKT_MODE || (pkt_cnt != '0) || (state_q == ST_CUT);
   assign srl_load  = out_free && (srl_cnt != '0) && load_ok;
   assign bypass    = out_free && (srl_cnt == '0) && wr_acc && (!PKT_MODE || s_last);
   assign srl_wr    = wr_acc && !bypass;
   assign rd_idx    = AWIDTH'(srl_cnt - ONE_C);
   assign head_word = srl_mem[rd_idx];
   assign head_last = head_word[DWIDTH];
   assign pkt_inc   = srl_wr & s_last;
   assign pkt_dec   = srl_load & head_last;

   assign dcount       = srl_cnt + (AWIDTH+1)'(m_valid);
   assign almost_full  = (dcount >= AF_C);
   assign almost_empty = (dcount <= AE_C);

   // Shift register storage: no reset, contents become unreachable once srl_cnt clears.
   always_ff @(posedge clk) begin
      if (srl_wr) begin
         srl_mem[0] <= {s_last, s_data};
         for (int i = 1; i < DEPTH; i++) srl_mem[i] <= srl_mem[i-1];
      end
   end

   // A packet that fills the SRL without a last can never complete, so release it cut-through.
   always_comb begin
      state_d  = state_q;
      oversize = 1'b0;
      if (PKT_MODE) begin
         case (state_q)
            ST_STORE: if (srl_cnt == DEPTH_C && pkt_cnt == '0) begin
               state_d  = ST_CUT;
               oversize = 1'b1;
            end
            ST_CUT: if ((srl_load && head_last) || (bypass && s_last)) state_d = ST_STORE;
            default: state_d = ST_STORE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_STORE;
         srl_cnt <= '0;
         pkt_cnt <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else begin
         state_q <= state_d;
         case ({srl_wr, srl_load})
            2'b10:   srl_cnt <= srl_cnt + ONE_C;
            2'b01:   srl_cnt <= srl_cnt - ONE_C;
            default: srl_cnt <= srl_cnt;
         endcase
         case ({pkt_inc, pkt_dec})
            2'b10:   pkt_cnt <= pkt_cnt + ONE_C;
            2'b01:   pkt_cnt <= pkt_cnt - ONE_C;
            default: pkt_cnt <= pkt_cnt;
         endcase
         if (out_free) begin
            if (srl_load) begin
               m_valid <= 1'b1;
               m_data  <= head_word[DWIDTH-1:0];
               m_last  <= head_last;
            end else if (bypass) begin
               m_valid <= 1'b1;
               m_data  <= s_data;
               m_last  <= s_last;
            end else begin
               m_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_srl_stream.sv
// Bench for sync_fifo_srl_stream: cut-through instance [0] and store-and-forward instance [1].
module tb_sync_fifo_srl_stream;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [15:0] s_data  [2];
   logic        s_last  [2];
   logic        s_valid [2];
   logic        s_ready [2];
   logic [15:0] m_data  [2];
   logic        m_last  [2];
   logic        m_valid [2];
   logic        m_ready [2];
   logic [4:0]  dcount  [2];
   logic        afull   [2];
   logic        aempty  [2];
   logic        ovs     [2];

   int n_cmp = 0;
   int n_err = 0;
   int ov_cnt = 0;
   logic [16:0] q0[$];
   logic [16:0] q1[$];
   bit          stall [2] = '{1'b0, 1'b0};
   logic [16:0] held  [2];

   always #5 clk = ~clk;

   sync_fifo_srl_stream #(.DWIDTH(16), .AWIDTH(4), .PKT_MODE(1'b0)) u_ct (
      .clk(clk), .arst_n(arst_n),
      .s_data(s_data[0]), .s_last(s_last[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
      .m_data(m_data[0]), .m_last(m_last[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
      .dcount(dcount[0]), .almost_full(afull[0]), .almost_empty(aempty[0]), .oversize(ovs[0]));

   sync_fifo_srl_stream #(.DWIDTH(16), .AWIDTH(4), .PKT_MODE(1'b1)) u_pk (
      .clk(clk), .arst_n(arst_n),
      .s_data(s_data[1]), .s_last(s_last[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
      .m_data(m_data[1]), .m_last(m_last[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
      .dcount(dcount[1]), .almost_full(afull[1]), .almost_empty(aempty[1]), .oversize(ovs[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int k, input logic [15:0] d, input logic l);
      s_data[k]  = d;
      s_last[k]  = l;
      s_valid[k] = 1'b1;
      for (int c = 0; c < 100 && !s_ready[k]; c++) tick();
      if (!s_ready[k]) chk("send_timeout", 32'(s_ready[k]), 32'd1);
      tick();
      s_valid[k] = 1'b0;
   endtask

   task automatic wait_empty(input int k);
      for (int c = 0; c < 200 && dcount[k] != 5'd0; c++) tick();
      chk("drain", 32'(dcount[k]), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_s_ready"}, 32'(s_ready[0]), 32'd1);
      chk({tag, "_m_valid"}, 32'(m_valid[0]), 32'd0);
      chk({tag, "_m_data"},  32'(m_data[0]),  32'd0);
      chk({tag, "_m_last"},  32'(m_last[0]),  32'd0);
      chk({tag, "_dcount"},  32'(dcount[0]),  32'd0);
      chk({tag, "_afull"},   32'(afull[0]),   32'd0);
      chk({tag, "_aempty"},  32'(aempty[0]),  32'd1);
      chk({tag, "_oversize"}, 32'(ovs[1]),    32'd0);
   endtask

   // Scoreboard monitor: accepted writes are queued, every output handshake pops and compares.
   always @(negedge clk or negedge arst_n) begin
      if (!arst_n) begin
         q0.delete();
         q1.delete();
         stall = '{1'b0, 1'b0};
      end else begin
         for (int k = 0; k < 2; k++) begin
            logic [16:0] e;
            bit          have;
            if (stall[k]) chk("hold_stable", {15'd0, m_valid[k], m_last[k], m_data[k]}, {15'd0, 1'b1, held[k]});
            if (m_valid[k] && m_ready[k]) begin
               have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
               if (!have) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL underflow_%0d: got word %0h, expected none", k, m_data[k]);
               end else begin
                  if (k == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  chk("order", {15'd0, m_last[k], m_data[k]}, {15'd0, e});
               end
            end
            if (s_valid[k] && s_ready[k]) begin
               if (k == 0) q0.push_back({s_last[k], s_data[k]});
               else        q1.push_back({s_last[k], s_data[k]});
            end
            stall[k] = m_valid[k] & ~m_ready[k];
            held[k]  = {m_last[k], m_data[k]};
         end
         if (ovs[1]) ov_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         s_data[k] = '0; s_last[k] = 1'b0; s_valid[k] = 1'b0; m_ready[k] = 1'b0;
      end
      #12;
      chk_reset_vals("rst");
      @(negedge clk);
      arst_n = 1'b1;
      tick();

      // Fill to capacity with the consumer stalled, then drain.
      for (int i = 1; i <= 17; i++) begin
         send(0, 16'(i), 1'b0);
         chk("fill_dcount", 32'(dcount[0]), 32'(i));
         chk("fill_afull", 32'(afull[0]), 32'(i >= 14));
      end
      chk("full_s_ready", 32'(s_ready[0]), 32'd0);
      m_ready[0] = 1'b1;
      for (int j = 1; j <= 17; j++) begin
         tick();
         chk("drain_dcount", 32'(dcount[0]), 32'(17 - j));
         chk("drain_aempty", 32'(aempty[0]), 32'((17 - j) <= 1));
      end
      chk("q0_empty_t1", 32'(q0.size()), 32'd0);

      // Bypass into an empty FIFO.
      send(0, 16'hA5A5, 1'b0);
      chk("byp_m_valid", 32'(m_valid[0]), 32'd1);
      chk("byp_m_data", 32'(m_data[0]), 32'hA5A5);
      chk("byp_dcount", 32'(dcount[0]), 32'd1);
      tick();
      chk("byp_dcount_after", 32'(dcount[0]), 32'd0);

      // Hold 8 words, then stream in and out together.
      m_ready[0] = 1'b0;
      for (int i = 0; i < 8; i++) send(0, 16'h0100 + 16'(i), 1'b0);
      chk("hold8_dcount", 32'(dcount[0]), 32'd8);
      m_ready[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send(0, 16'h0200 + 16'(i), 1'b0);
         chk("stream_dcount", 32'(dcount[0]), 32'd8);
      end
      wait_empty(0);

      // Store-and-forward: 5-word packet held until its last is in.
      m_ready[1] = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         send(1, 16'h0300 + 16'(i), i == 5);
         chk("sf_hold_m_valid", 32'(m_valid[1]), 32'd0);
      end
      tick();
      chk("sf_first_valid", 32'(m_valid[1]), 32'd1);
      chk("sf_first_data", 32'(m_data[1]), 32'h0301);
      for (int i = 2; i <= 5; i++) begin
         tick();
         chk("sf_b2b_valid", 32'(m_valid[1]), 32'd1);
         chk("sf_b2b_data", 32'(m_data[1]), 32'h0300 + 32'(i));
         chk("sf_b2b_last", 32'(m_last[1]), 32'(i == 5));
      end
      tick();
      chk("sf_done_valid", 32'(m_valid[1]), 32'd0);
      chk("ov_none", 32'(ov_cnt), 32'd0);

      // Oversize packet falls back to cut-through, then store resumes.
      for (int i = 1; i <= 20; i++) send(1, 16'h0400 + 16'(i), i == 20);
      wait_empty(1);
      chk("ov_once", 32'(ov_cnt), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         send(1, 16'h0500 + 16'(i), i == 3);
         chk("post_ov_hold", 32'(m_valid[1]), 32'd0);
      end
      tick();
      chk("post_ov_valid", 32'(m_valid[1]), 32'd1);
      chk("post_ov_data", 32'(m_data[1]), 32'h0501);
      wait_empty(1);

      // Asynchronous reset while holding 6 words.
      m_ready[0] = 1'b0;
      for (int i = 0; i < 6; i++) send(0, 16'h0600 + 16'(i), 1'b0);
      chk("pre_rst_dcount", 32'(dcount[0]), 32'd6);
      #2;
      arst_n = 1'b0;
      #1;
      chk_reset_vals("arst");
      #1;
      arst_n = 1'b1;
      tick();
      send(0, 16'h0700, 1'b0);
      chk("post_rst_valid", 32'(m_valid[0]), 32'd1);
      chk("post_rst_data", 32'(m_data[0]), 32'h0700);
      chk("post_rst_dcount", 32'(dcount[0]), 32'd1);
      m_ready[0] = 1'b1;
      tick();
      chk("post_rst_drain", 32'(dcount[0]), 32'd0);
      tick();

      chk("q0_leftover", 32'(q0.size()), 32'd0);
      chk("q1_leftover", 32'(q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sync_fifo_srl_stream.md
# sync_fifo_srl_stream

Shallow SRL-based synchronous FIFO with a valid/ready streaming interface, first-word-fall-through registered output, and programmable almost-full/almost-empty flags. An optional packet (store-and-forward) mode holds output until a complete `last`-terminated packet is buffered, and falls back to cut-through for oversize packets. It sits between packet-processing stages of the 1GE datapath where shallow elastic buffering with back-pressure is needed.

## Interface
- `DWIDTH`, 16: payload width.
- `AWIDTH`, 4: SRL depth is 2^AWIDTH. Legal range is 4..8. Total capacity is 2^AWIDTH+1 (SRL plus output register).
- `PKT_MODE`, 0: 0 selects cut-through; 1 selects store-and-forward.
- `AFULL_LVL`, 2^AWIDTH-2: `almost_full` threshold.
- `AEMPTY_LVL`, 1: `almost_empty` threshold.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state changes on posedge.
- `arst_n`  in  1  asynchronous active-low reset.
- `s_data`  in  DWIDTH  write data.
- `s_last`  in  1  end-of-packet marker, stored alongside data.
- `s_valid`  in  1  write request.
- `s_ready`  out  1  write accept; equals SRL-not-full.
- `m_data`  out  DWIDTH  registered head data.
- `m_last`  out  1  registered head end-of-packet marker.
- `m_valid`  out  1  output register holds a word.
- `m_ready`  in  1  consumer accept.
- `dcount`  out  AWIDTH+1  total occupancy, equal to SRL words plus `m_valid`.
- `almost_full`  out  1  asserted when `dcount >= AFULL_LVL`.
- `almost_empty`  out  1  asserted when `dcount <= AEMPTY_LVL`.
- `oversize`  out  1  one-cycle pulse when the block enters cut-through fallback.

## Operation
- **Storage:** an SRL of (DWIDTH+1)-bit words {last, data}, shifted in on an SRL write. Read address is `srl_cnt-1`, so the oldest word is the head.
- **Handshakes:** a write is accepted when `s_valid & s_ready`. A pop happens when `m_valid & m_ready`.
- **s_ready:** `s_ready = (srl_cnt != 2^AWIDTH)`. It is decoded from registers only, with no combinational path from `m_ready`. A full SRL rejects writes even in a cycle that pops.
- **Output register** is free when `!m_valid | m_ready`. When free, it loads by priority:
  - **SRL load:** taken when `srl_cnt>0` and `load_ok`. The head word moves to the output register.
  - **Bypass:** taken when `srl_cnt==0`, a write is accepted, and (`PKT_MODE==0` or `s_last`). `s_data`/`s_last` load directly and the SRL is not written.
  - **Otherwise:** a pop clears `m_valid`.
- **load_ok:** `PKT_MODE==0`, or `pkt_cnt>0`, or state CUT.
- **pkt_cnt:** counts last-flagged words inside the SRL, width AWIDTH+1.
  - +1 on an SRL write with `s_last`.
  - -1 on an SRL load of a last word.
  - Both in the same cycle leave it unchanged.
- **Packet FSM** (PKT_MODE=1 only; held in STORE when PKT_MODE=0):
  - STORE→CUT when `srl_cnt==2^AWIDTH & pkt_cnt==0`. `oversize` pulses for that cycle.
  - CUT→STORE on the cycle a last word loads into the output register.
- **srl_cnt:** +1 on write-only, -1 on load-only, unchanged on simultaneous write and load. Range is 0..2^AWIDTH.

## Timing
- **Reset values:** `s_ready=1`, `m_valid=0`, `m_data=0`, `m_last=0`, `dcount=0`, `almost_full=0`, `almost_empty=1`, `oversize=0`. Internally, `srl_cnt=0`, `pkt_cnt=0`, state STORE.
- Reset asserted mid-stream discards all contents immediately. The SRL array is not cleared, but is unreachable.
- **Cut-through latency:** a word accepted at edge N into an empty FIFO shows `m_valid` after edge N, via bypass. A word that lands in the SRL appears one edge after the output register frees.
- **Store-and-forward latency:** the first word shows `m_valid` one edge after the edge accepting its `last`, or after the same edge for a single-word packet (bypass).
- **Sustained throughput:** one word per cycle in each direction with continuous `m_ready`.
- `m_data`/`m_last` hold stable while `m_valid & !m_ready`.
- **Decoded flags:** `dcount`, `almost_*`, and `s_ready` are decoded from registered state and update the cycle after the causing edge.

## Test plan
- **Reset and cut-through:** reset, then write 0x0001..0x0011 (17 words) with `m_ready=0`.
  - `s_ready` drops after word 17 and `dcount=17`.
  - `almost_full` is set from `dcount=14`.
  - Then `m_ready=1` drains the words in order, 1/cycle, with `almost_empty` asserting at `dcount<=1`.
- **Bypass latency:** on an empty FIFO with `m_ready=1`, write 0xA5A5 at edge N.
  - `m_valid=1` and `m_data=0xA5A5` after edge N.
  - `dcount` returns to 0 after N+1.
- **Simultaneous read/write:** hold 8 words, then stream writes and pops together for 20 cycles.
  - `dcount` stays 8.
  - Data order is preserved and there is no underflow or overflow.
- **Store-and-forward (PKT_MODE=1):** write a 5-word packet with `last` on word 5, at 1 word/cycle.
  - `m_valid` stays 0 until one edge after word 5 is accepted.
  - Then 5 words come out back-to-back with `m_last` on the 5th.
- **Oversize (PKT_MODE=1, AWIDTH=4):** write a 20-word packet.
  - `oversize` pulses once when the SRL fills.
  - Words flow cut-through.
  - The state returns to STORE on `last`.
  - A following 3-word packet is held until complete.
- **Async reset mid-operation:** pulse `arst_n` low between edges while the FIFO holds 6 words.
  - All outputs take their reset values immediately.
  - The next write behaves as if into an empty FIFO.
